multicycle_control: RTL and testbench

Sequencing controller for the multicycle MIPS datapath. It replaces the single-cycle `ControlUnit` decode in the multicycle build. The block runs a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback, one datapath stage per clock. It drives every mux select and write enable in the datapath, stalls on a memory-ready handshake, and flags unsupported opcodes.

---
 rtl/multicycle_control.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencer for the multicycle MIPS datapath, one stage per clock, opcode decode in DECODE.
// Latency: R-type/SW/ADDI 4, LW 5, BEQ/J 3 cycles; mem_ready stalls FETCH/MEMRD/MEMWR, MEM_WAIT_MAX bounds a stall.
// Define MC_ADDI_EN to build the ADDIEX/ADDIWB states; otherwise opcode 001000 is flagged illegal.
module multicycle_control #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
`ifdef MC_ADDI_EN
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
`endif
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_MAX - 1);

  state_t     cur, nxt;
  logic [3:0] wait_cnt, wait_cnt_d;
  logic       waiting, timeout;
  logic       irwrite, pcwrite, branch, regwrite, memwrite, illegal;

  // Funct is decoded by the ALU decoder downstream, not by the sequencer.
  logic unused_funct;
  assign unused_funct = ^Funct;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= FETCH;
      wait_cnt <= 4'd0;
    end else begin
      cur      <= nxt;
      wait_cnt <= wait_cnt_d;
    end
  end

  always_comb begin
    nxt      = FETCH;
    IorD     = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 3'b000;
    PCSrc    = 2'b00;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    regwrite = 1'b0;
    memwrite = 1'b0;
    illegal  = 1'b0;
    waiting  = 1'b0;
    case (cur)
      FETCH: begin
        ALUSrcB = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        waiting = !mem_ready;
        nxt     = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_RTYPE:     nxt = EXECUTE;
          OP_LW, OP_SW: nxt = MEMADR;
          OP_BEQ:       nxt = BRANCH;
`ifdef MC_ADDI_EN
          OP_ADDI:      nxt = ADDIEX;
`endif
          OP_J:         nxt = JUMP;
          default:      illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (opcode == OP_LW)      nxt = MEMRD;
        else if (opcode == OP_SW) nxt = MEMWR;
      end
      MEMRD: begin
        IorD    = 1'b1;
        waiting = !mem_ready;
        nxt     = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        memwrite = 1'b1;
        waiting  = !mem_ready;
        nxt      = mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b010;
        nxt     = ALUWB;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b001;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
`ifdef MC_ADDI_EN
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = ADDIWB;
      end
      ADDIWB: regwrite = 1'b1;
`endif
      JUMP: begin
        PCSrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: nxt = FETCH;
    endcase

    // A stall that hits the limit abandons the instruction without touching PC, IR or memory.
    timeout = waiting && (wait_cnt == WAIT_LAST);
    if (timeout) begin
      nxt      = FETCH;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      memwrite = 1'b0;
    end

    // Counter only survives across consecutive waiting cycles of one state.
    wait_cnt_d = 4'd0;
    if (waiting && !timeout)
      wait_cnt_d = (wait_cnt == 4'hF) ? wait_cnt : wait_cnt + 4'd1;
  end

  // Enables are gated by rst_n so they drop the moment reset asserts.
  assign IRWrite     = rst_n & irwrite;
  assign PCEn        = rst_n & (pcwrite | (branch & Zero));
  assign RegWrite    = rst_n & regwrite;
  assign MemWrite    = rst_n & memwrite;
  assign illegal_op  = rst_n & illegal;
  assign mem_timeout = rst_n & timeout;
  assign state       = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle stimulus and expected state/enables/selects are queued, then replayed.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, Funct;
  logic       Zero, mem_ready;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUOp;
  logic       PCEn, illegal_op, mem_timeout;
  logic [3:0] state;

  multicycle_control #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // en = {IRWrite, PCEn, RegWrite, MemWrite, illegal_op, mem_timeout}
  localparam logic [5:0] EN_NONE = 6'b000000;
  localparam logic [5:0] EN_FET  = 6'b110000;
  localparam logic [5:0] EN_PC   = 6'b010000;
  localparam logic [5:0] EN_RW   = 6'b001000;
  localparam logic [5:0] EN_MW   = 6'b000100;
  localparam logic [5:0] EN_ILL  = 6'b000010;
  localparam logic [5:0] EN_TO   = 6'b000001;

  typedef struct packed {logic [5:0] op; logic [5:0] fn; logic z; logic rdy;} stim_t;
  typedef struct packed {logic [3:0] st; logic [5:0] en; logic [10:0] sel;} exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // sel = {IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc} per state
  function automatic logic [10:0] sel_of(input logic [3:0] st);
    case (st)
      4'd0:    return 11'b0_0_0_0_01_000_00;
      4'd1:    return 11'b0_0_0_0_11_000_00;
      4'd2:    return 11'b0_0_0_1_10_000_00;
      4'd3:    return 11'b1_0_0_0_00_000_00;
      4'd4:    return 11'b0_0_1_0_00_000_00;
      4'd5:    return 11'b1_0_0_0_00_000_00;
      4'd6:    return 11'b0_0_0_1_00_010_00;
      4'd7:    return 11'b0_1_0_0_00_000_00;
      4'd8:    return 11'b0_0_0_1_00_001_01;
      4'd9:    return 11'b0_0_0_1_10_000_00;
      4'd11:   return 11'b0_0_0_0_00_000_10;
      default: return 11'b0;
    endcase
  endfunction

  task automatic push(input logic [5:0] op, input logic z, input logic rdy,
                      input logic [3:0] st, input logic [5:0] en);
    stim_t s;
    exp_t  e;
    s = '{op: op, fn: 6'b100000, z: z, rdy: rdy};
    e = '{st: st, en: en, sel: sel_of(st)};
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Entered one time unit after a rising edge; each entry covers one clock cycle.
  task automatic run(input string name);
    stim_t s;
    exp_t  e;
    int    cyc;
    cyc = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      opcode = s.op; Funct = s.fn; Zero = s.z; mem_ready = s.rdy;
      @(negedge clk);
      check($sformatf("%s.c%0d.state", name, cyc), 32'(state), 32'(e.st));
      check($sformatf("%s.c%0d.en", name, cyc),
            32'({IRWrite, PCEn, RegWrite, MemWrite, illegal_op, mem_timeout}), 32'(e.en));
      check($sformatf("%s.c%0d.sel", name, cyc),
            32'({IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc}), 32'(e.sel));
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    rst_n = 1'b1; opcode = OP_R; Funct = 6'b100000; Zero = 1'b0; mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset.state", 32'(state), 32'd0);
    check("reset.en", 32'({IRWrite, PCEn, RegWrite, MemWrite, illegal_op, mem_timeout}), 32'(EN_NONE));
    check("reset.sel", 32'({IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc}), 32'(sel_of(4'd0)));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.hold_state", 32'(state), 32'd0);
    check("reset.hold_irwrite", 32'(IRWrite), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // R-type; mem_ready low outside FETCH must not stall
    push(OP_R, 0, 1, 0, EN_FET); push(OP_R, 0, 0, 1, EN_NONE);
    push(OP_R, 0, 0, 6, EN_NONE); push(OP_R, 0, 0, 7, EN_RW);
    run("rtype");

    // LW with 3 wait cycles in MEMRD
    push(OP_LW, 0, 1, 0, EN_FET); push(OP_LW, 0, 1, 1, EN_NONE); push(OP_LW, 0, 1, 2, EN_NONE);
    repeat (3) push(OP_LW, 0, 0, 3, EN_NONE);
    push(OP_LW, 0, 1, 3, EN_NONE); push(OP_LW, 0, 1, 4, EN_RW);
    run("lw");

    push(OP_SW, 0, 1, 0, EN_FET); push(OP_SW, 0, 1, 1, EN_NONE);
    push(OP_SW, 0, 1, 2, EN_NONE); push(OP_SW, 0, 1, 5, EN_MW);
    run("sw");

    // Zero=1 throughout: only BRANCH may turn it into PCEn
    push(OP_BEQ, 1, 1, 0, EN_FET); push(OP_BEQ, 1, 1, 1, EN_NONE); push(OP_BEQ, 1, 1, 8, EN_PC);
    run("beq_taken");
    push(OP_BEQ, 0, 1, 0, EN_FET); push(OP_BEQ, 0, 1, 1, EN_NONE); push(OP_BEQ, 0, 1, 8, EN_NONE);
    run("beq_not");

    push(OP_J, 0, 1, 0, EN_FET); push(OP_J, 0, 1, 1, EN_NONE); push(OP_J, 0, 1, 11, EN_PC);
    run("jump");

    push(OP_BAD, 0, 1, 0, EN_FET); push(OP_BAD, 0, 1, 1, EN_ILL);
    run("illegal");

`ifdef MC_ADDI_EN
    push(OP_ADDI, 0, 1, 0, EN_FET); push(OP_ADDI, 0, 1, 1, EN_NONE);
    push(OP_ADDI, 0, 1, 9, EN_NONE); push(OP_ADDI, 0, 1, 10, EN_RW);
`else
    push(OP_ADDI, 0, 1, 0, EN_FET); push(OP_ADDI, 0, 1, 1, EN_ILL);
`endif
    run("addi");

    // FETCH stall: timeout on the 15th waiting cycle, counter restarts afterwards
    repeat (14) push(OP_R, 0, 0, 0, EN_NONE);
    push(OP_R, 0, 0, 0, EN_TO);
    push(OP_R, 0, 0, 0, EN_NONE);
    run("timeout");

    // Reset in the second MEMWR wait cycle
    push(OP_SW, 0, 1, 0, EN_FET); push(OP_SW, 0, 1, 1, EN_NONE);
    push(OP_SW, 0, 1, 2, EN_NONE); push(OP_SW, 0, 0, 5, EN_MW);
    run("memwr");
    mem_ready = 1'b0;
    @(negedge clk);
    check("memwr.wait2_state", 32'(state), 32'd5);
    check("memwr.wait2_memwrite", 32'(MemWrite), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("memwr.rst_memwrite", 32'(MemWrite), 32'd0);
    check("memwr.rst_state", 32'(state), 32'd0);
    mem_ready = 1'b1;
    #1;
    check("memwr.rst_irwrite", 32'(IRWrite), 32'd0);
    check("memwr.rst_pcen", 32'(PCEn), 32'd0);
    @(negedge clk);
    check("memwr.rst_hold_memwrite", 32'(MemWrite), 32'd0);
    check("memwr.rst_hold_state", 32'(state), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    push(OP_J, 0, 1, 0, EN_FET); push(OP_J, 0, 1, 1, EN_NONE); push(OP_J, 0, 1, 11, EN_PC);
    push(OP_J, 0, 1, 0, EN_FET);
    run("recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
